// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - move history stack with apply/undo issue sequencing
module move_sequencer #(
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic        cmd_undo,
    output logic        cmd_ready,
    input  logic [5:0]  fromSquare,
    input  logic [5:0]  toSquare,
    input  logic [5:0]  movingPiece_in,
    input  logic [5:0]  capturedPiece_in,
    input  logic [2:0]  castling_in,
    input  logic [4:0]  enpassant_in,
    input  logic        color_in,
    output logic [63:0] initialPosition,
    output logic [63:0] movedPosition,
    output logic [5:0]  movingPiece,
    output logic [5:0]  capturedPiece,
    output logic [2:0]  castling,
    output logic [4:0]  enpassant,
    output logic        color_type,
    output logic        undo,
    output logic        enable,
    output logic [5:0]  depth,
    output logic        stack_full,
    output logic        stack_empty,
    output logic        error
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] DEPTH_MAX = 6'(DEPTH);
    localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [3:0]     hold_cnt;
    logic [32:0]    mem [DEPTH];
    logic [32:0]    push_entry;
    logic [32:0]    top_entry;
    logic [32:0]    load_entry;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic           accept;
    logic           bad_apply;
    logic           bad_undo;
    logic           reject;
    logic           do_apply;
    logic           do_undo;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    assign cmd_ready   = (state == IDLE);
    assign enable      = (state == ISSUE);
    assign stack_full  = (depth == DEPTH_MAX);
    assign stack_empty = (depth == 6'd0);

    // Command qualification and next-state selection; inputs only matter in IDLE
    always_comb begin
        state_next = state;
        accept     = (state == IDLE) && cmd_valid;
        bad_apply  = stack_full
                   || !is_onehot6(movingPiece_in)
                   || ((capturedPiece_in != 6'd0) && !is_onehot6(capturedPiece_in))
                   || (fromSquare == toSquare);
        bad_undo   = stack_empty;
        reject     = accept && (cmd_undo ? bad_undo : bad_apply);
        do_apply   = accept && !cmd_undo && !bad_apply;
        do_undo    = accept && cmd_undo && !bad_undo;
        wr_addr    = AW'(depth);
        rd_addr    = AW'(depth - 6'd1);
        push_entry = {fromSquare, toSquare, movingPiece_in, capturedPiece_in,
                      castling_in, enpassant_in, color_in};
        top_entry  = mem[rd_addr];
        load_entry = cmd_undo ? top_entry : push_entry;
        case (state)
            IDLE:    if (do_apply || do_undo) state_next = ISSUE;
            ISSUE:   state_next = HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // History RAM; not cleared, stale entries are hidden by depth returning to 0
    always_ff @(posedge clk) begin
        if (reset_n && do_apply) mem[wr_addr] <= push_entry;
    end

    // Depth, hold counter, error pulse and issued outputs, loaded only on an accepted command
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth           <= 6'd0;
            hold_cnt        <= 4'd0;
            error           <= 1'b0;
            undo            <= 1'b0;
            initialPosition <= 64'd0;
            movedPosition   <= 64'd0;
            movingPiece     <= 6'd0;
            capturedPiece   <= 6'd0;
            castling        <= 3'b001;
            enpassant       <= 5'd0;
            color_type      <= 1'b0;
        end else begin
            error <= reject;
            if (state == ISSUE)     hold_cnt <= 4'd0;
            else if (state == HOLD) hold_cnt <= hold_cnt + 4'd1;
            if (do_apply) depth <= depth + 6'd1;
            if (do_undo)  depth <= depth - 6'd1;
            if (do_apply || do_undo) begin
                initialPosition <= 64'd1 << load_entry[32:27];
                movedPosition   <= 64'd1 << load_entry[26:21];
                movingPiece     <= load_entry[20:15];
                capturedPiece   <= load_entry[14:9];
                castling        <= load_entry[8:6];
                enpassant       <= load_entry[5:1];
                color_type      <= load_entry[0];
                undo            <= do_undo;
            end
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed self-checking bench for move_sequencer
module tb_move_sequencer;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_undo;
    logic        cmd_ready;
    logic [5:0]  fromSquare;
    logic [5:0]  toSquare;
    logic [5:0]  movingPiece_in;
    logic [5:0]  capturedPiece_in;
    logic [2:0]  castling_in;
    logic [4:0]  enpassant_in;
    logic        color_in;
    logic [63:0] initialPosition;
    logic [63:0] movedPosition;
    logic [5:0]  movingPiece;
    logic [5:0]  capturedPiece;
    logic [2:0]  castling;
    logic [4:0]  enpassant;
    logic        color_type;
    logic        undo;
    logic        enable;
    logic [5:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [32:0] stk [$];
    logic [63:0] exp_init;
    logic [63:0] exp_moved;
    logic [20:0] exp_fields;
    logic        exp_undo;

    move_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_undo(cmd_undo),
        .cmd_ready(cmd_ready), .fromSquare(fromSquare), .toSquare(toSquare),
        .movingPiece_in(movingPiece_in), .capturedPiece_in(capturedPiece_in),
        .castling_in(castling_in), .enpassant_in(enpassant_in), .color_in(color_in),
        .initialPosition(initialPosition), .movedPosition(movedPosition),
        .movingPiece(movingPiece), .capturedPiece(capturedPiece), .castling(castling),
        .enpassant(enpassant), .color_type(color_type), .undo(undo), .enable(enable),
        .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_reset_exp();
        exp_init   = 64'd0;
        exp_moved  = 64'd0;
        exp_fields = {6'd0, 6'd0, 3'b001, 5'd0, 1'b0};
        exp_undo   = 1'b0;
    endtask

    task automatic set_exp(input logic [32:0] e, input logic u);
        exp_init   = 64'd1 << e[32:27];
        exp_moved  = 64'd1 << e[26:21];
        exp_fields = e[20:0];
        exp_undo   = u;
    endtask

    function automatic logic out_ok();
        return (initialPosition === exp_init) && (movedPosition === exp_moved)
            && ({movingPiece, capturedPiece, castling, enpassant, color_type} === exp_fields)
            && (undo === exp_undo);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after a rejected accept
    task automatic err_checks(input string tag);
        chk({tag, "_err"}, error, 1'b1);
        chk({tag, "_en"}, enable, 1'b0);
        chk({tag, "_rdy"}, cmd_ready, 1'b1);
        chk({tag, "_depth"}, depth, 6'(stk.size()));
        chk({tag, "_outs"}, out_ok(), 1'b1);
        tick();
        chk({tag, "_err_end"}, error, 1'b0);
    endtask

    // Called in the ISSUE cycle; then walks HOLD back to IDLE
    task automatic issue_checks(input string tag, input logic [32:0] e, input logic u);
        int n;
        int bad;
        set_exp(e, u);
        chk({tag, "_en"}, enable, 1'b1);
        chk({tag, "_outs"}, out_ok(), 1'b1);
        chk({tag, "_undo"}, undo, u);
        chk({tag, "_depth"}, depth, 6'(stk.size()));
        chk({tag, "_rdy"}, cmd_ready, 1'b0);
        n   = 1;
        bad = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            if (!cmd_ready) n++;
            if (enable || !out_ok() || error) bad++;
        end
        chk({tag, "_busy"}, n, 1 + SETTLE);
        chk({tag, "_hold"}, bad, 0);
    endtask

    task automatic apply(input string tag, input logic [5:0] f, input logic [5:0] t,
                         input logic [5:0] m, input logic [5:0] c, input logic [2:0] ca,
                         input logic [4:0] ep, input logic col, input logic exp_err);
        logic [32:0] e;
        e = {f, t, m, c, ca, ep, col};
        fromSquare = f; toSquare = t; movingPiece_in = m; capturedPiece_in = c;
        castling_in = ca; enpassant_in = ep; color_in = col;
        cmd_undo = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (exp_err) begin
            err_checks(tag);
        end else begin
            stk.push_back(e);
            issue_checks(tag, e, 1'b0);
        end
    endtask

    task automatic do_undo(input string tag, input logic exp_err);
        logic [32:0] e;
        cmd_undo = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_undo = 1'b0;
        if (exp_err) begin
            err_checks(tag);
        end else begin
            e = stk.pop_back();
            issue_checks(tag, e, 1'b1);
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_undo = 1'b0;
        fromSquare = 6'd0; toSquare = 6'd0; movingPiece_in = 6'd0; capturedPiece_in = 6'd0;
        castling_in = 3'b001; enpassant_in = 5'd0; color_in = 1'b0;
        set_reset_exp();
        tick();
        tick();
        chk("rst_depth", depth, 6'd0);
        chk("rst_empty", stack_empty, 1'b1);
        chk("rst_full", stack_full, 1'b0);
        chk("rst_en", enable, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_castling", castling, 3'b001);
        chk("rst_outs", out_ok(), 1'b1);
        reset_n = 1'b1;
        chk("rst_rdy", cmd_ready, 1'b1);

        // First move with constants: e2-e4 style square 12 -> 28, pawn, quiet
        fromSquare = 6'd12; toSquare = 6'd28; movingPiece_in = 6'b000001;
        capturedPiece_in = 6'd0; castling_in = 3'b001; enpassant_in = 5'b00001; color_in = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("m1_init_const", initialPosition, 64'h0000_0000_0000_1000);
        chk("m1_moved_const", movedPosition, 64'h0000_0000_1000_0000);
        chk("m1_depth_const", depth, 6'd1);
        stk.push_back({6'd12, 6'd28, 6'b000001, 6'd0, 3'b001, 5'b00001, 1'b0});
        issue_checks("m1", {6'd12, 6'd28, 6'b000001, 6'd0, 3'b001, 5'b00001, 1'b0}, 1'b0);

        // Inputs ignored while cmd_valid is low
        cmd_undo = 1'b1;
        tick(); tick(); tick();
        cmd_undo = 1'b0;
        chk("idle_depth", depth, 6'd1);
        chk("idle_en", enable, 1'b0);

        do_undo("u1", 1'b0);
        chk("u1_empty", stack_empty, 1'b1);
        do_undo("u_empty", 1'b1);
        apply("bad_moving", 6'd1, 6'd2, 6'b000011, 6'd0, 3'b001, 5'd0, 1'b0, 1'b1);
        apply("bad_capt", 6'd1, 6'd2, 6'b000001, 6'b000110, 3'b001, 5'd0, 1'b0, 1'b1);
        apply("bad_same", 6'd9, 6'd9, 6'b000100, 6'd0, 3'b001, 5'd0, 1'b0, 1'b1);
        apply("bad_zero", 6'd1, 6'd2, 6'b000000, 6'd0, 3'b001, 5'd0, 1'b0, 1'b1);

        // Three moves, undo twice returns 3rd then 2nd, then empty the stack
        apply("a1", 6'd12, 6'd28, 6'b000001, 6'd0, 3'b001, 5'b00001, 1'b0, 1'b0);
        apply("a2", 6'd52, 6'd36, 6'b000001, 6'd0, 3'b010, 5'b00010, 1'b1, 1'b0);
        apply("a3", 6'd5, 6'd33, 6'b001000, 6'b000100, 3'b100, 5'b10000, 1'b0, 1'b0);
        do_undo("r3", 1'b0);
        chk("r3_depth", depth, 6'd2);
        do_undo("r2", 1'b0);
        do_undo("r1", 1'b0);

        // Fill to DEPTH, overflow reject, then drain in LIFO order
        for (int i = 0; i < DEPTH; i++) begin
            apply("fill", 6'(i), 6'(i + 20), 6'(1 << (i % 6)), (i % 3 == 0) ? 6'd0 : 6'b010000,
                  3'(1 << (i % 3)), 5'(1 << (i % 5)), i[0], 1'b0);
        end
        chk("fill_full", stack_full, 1'b1);
        chk("fill_depth", depth, 6'(DEPTH));
        apply("over", 6'd40, 6'd41, 6'b100000, 6'd0, 3'b001, 5'd0, 1'b1, 1'b1);
        chk("over_depth", depth, 6'(DEPTH));
        for (int i = 0; i < DEPTH; i++) do_undo("drain", 1'b0);
        chk("drain_empty", stack_empty, 1'b1);
        chk("drain_full", stack_full, 1'b0);

        // Reset during HOLD of the 5th apply
        for (int i = 0; i < 4; i++) begin
            apply("pre", 6'(i + 1), 6'(i + 40), 6'b000010, 6'd0, 3'b001, 5'd0, 1'b0, 1'b0);
        end
        fromSquare = 6'd7; toSquare = 6'd63; movingPiece_in = 6'b010000;
        capturedPiece_in = 6'b000001; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("r5_en", enable, 1'b1);
        chk("r5_depth", depth, 6'd5);
        tick();
        reset_n = 1'b0;
        tick();
        stk.delete();
        set_reset_exp();
        chk("rh_depth", depth, 6'd0);
        chk("rh_en", enable, 1'b0);
        chk("rh_outs", out_ok(), 1'b1);
        tick();
        chk("rh_en2", enable, 1'b0);
        reset_n = 1'b1;
        chk("rh_rdy", cmd_ready, 1'b1);
        tick();
        chk("rh_en3", enable, 1'b0);
        do_undo("rh_undo", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter DEPTH, 16, number of move-history entries; SHALL be a power of two, range 2..32.
REQ-002 Parameter SETTLE_CYCLES, 2, number of hold cycles after each issue pulse; range 1..15.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset is synchronous and active-low.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_undo  in  1  qualifies the command: 0 = apply move, 1 = undo last move.
REQ-007 cmd_ready  out  1  the block accepts a command on a cycle where cmd_valid and cmd_ready are both 1.
REQ-008 fromSquare, toSquare  in  6 each  square indices 0..63 (apply only).
REQ-009 movingPiece_in, capturedPiece_in  in  6 each  one-hot piece codes: pawn, rook, knight, bishop, queen, king = bits 0..5; captured may be 0 (quiet move).
REQ-010 castling_in  in  3  castling code, 001/010/100; enpassant_in  in  5  en-passant code, one-hot; color_in  in  1  mover colour.
REQ-011 initialPosition, movedPosition  out  64 each  one-hot square masks to the board updater.
REQ-012 movingPiece, capturedPiece  out  6 each; castling  out  3; enpassant  out  5; color_type  out  1; undo  out  1.
REQ-013 enable  out  1  one-cycle issue strobe.
REQ-014 depth  out  6  current entry count; stack_full, stack_empty  out  1 each.
REQ-015 error  out  1  one-cycle pulse on a rejected command.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and HOLD; cmd_ready SHALL be 1 only in IDLE.
REQ-017 Apply accept in IDLE: the block SHALL push {from, to, moving, captured, castling, enpassant, color}, 33 bits, at the top of the stack, increment depth and go to ISSUE.
REQ-018 Apply output: on the following cycle the block SHALL drive initialPosition = 1<<fromSquare, movedPosition = 1<<toSquare, the piece/castling/enpassant/colour fields and undo = 0.
REQ-019 Undo accept in IDLE: the block SHALL read the top entry, decrement depth and go to ISSUE.
REQ-020 Undo output: the block SHALL drive the entry fields exactly as recorded, with positions unswapped, and undo = 1.
REQ-021 enable SHALL be 1 only in the ISSUE state, for one cycle; the first-issue latency from accept to enable SHALL be 1 cycle.
REQ-022 ISSUE SHALL always go to HOLD; HOLD SHALL last SETTLE_CYCLES cycles, counted with a 4-bit counter, then return to IDLE.
REQ-023 All data outputs SHALL stay stable from ISSUE through the last HOLD cycle; in IDLE they SHALL keep their last values.
REQ-024 Reject conditions, checked at accept, are: apply with stack_full; apply with movingPiece_in not exactly one-hot; apply with capturedPiece_in neither zero nor one-hot; apply with fromSquare == toSquare; undo with stack_empty.
REQ-025 On a reject the block SHALL pulse error for one cycle, leave the stack, depth and outputs unchanged, and stay in IDLE.
REQ-026 On a reject, cmd_ready SHALL remain 1.
REQ-027 stack_full SHALL equal (depth == DEPTH); stack_empty SHALL equal (depth == 0).
REQ-028 The stack pointer SHALL never wrap: depth SHALL saturate at 0 and at DEPTH, per the reject rules.
REQ-029 cmd_undo SHALL be ignored when cmd_valid = 0.
REQ-030 Inputs present outside IDLE SHALL NOT be sampled.

Reset
REQ-031 While reset_n = 0 at a clock edge, the FSM SHALL be forced to IDLE.
REQ-032 While reset_n = 0 at a clock edge, depth SHALL be set to 0 and the HOLD counter cleared.
REQ-033 While reset_n = 0 at a clock edge, enable, error and undo SHALL be 0.
REQ-034 While reset_n = 0 at a clock edge, initialPosition, movedPosition, movingPiece, capturedPiece, enpassant and color_type SHALL be 0, and castling SHALL be 001.
REQ-035 Stack RAM contents need not be cleared on reset.
REQ-036 Reset asserted in ISSUE or HOLD SHALL abort the operation with no further enable strobe.
REQ-037 An entry pushed before reset SHALL be unreachable after reset.
REQ-038 cmd_ready SHALL be 1 on the first cycle after reset_n returns to 1.

Verification
REQ-039 Apply from=12, to=28, moving=000001, captured=0 -> next cycle enable=1, initialPosition=0x1000, movedPosition=0x10000000, undo=0, depth=1; cmd_ready=0 for 1+SETTLE_CYCLES cycles.
REQ-040 Apply 3 moves, then undo -> outputs equal the 3rd move's record with undo=1, depth=2; the second undo returns the 2nd record.
REQ-041 Undo at depth=0 -> error pulse of 1 cycle, no enable, depth stays 0; apply with moving=000011 -> error, no push.
REQ-042 Apply DEPTH times -> stack_full=1; an extra apply -> error, depth=DEPTH; then DEPTH undos -> stack_empty=1, issued in LIFO order.
REQ-043 Assert reset_n=0 in HOLD after an apply at depth 5 -> next cycle depth=0, enable=0, cmd_ready=1 after release; a following undo -> error.
